// File: rtl/cnn_pkg.sv
// Shared CNN datapath types, geometry and helpers for the pooling stage.
package cnn_pkg;

   localparam int unsigned DATA_W         = 12;
   localparam int unsigned IN_W           = 20;
   localparam int unsigned IN_H           = 20;
   localparam int unsigned CHANNELS       = 16;
   localparam int unsigned POOL_OUT_COUNT = (IN_W / 2) * (IN_H / 2) * CHANNELS;

   localparam int unsigned COL_W    = $clog2(IN_W);
   localparam int unsigned ROW_W    = $clog2(IN_H);
   localparam int unsigned CH_W     = $clog2(CHANNELS + 1);
   localparam int unsigned LB_DEPTH = IN_W / 2;
   localparam int unsigned LB_IDX_W = $clog2(LB_DEPTH);

   typedef logic signed [DATA_W-1:0] act_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } pool_state_t;

   // Signed maximum; ties return the common value.
   function automatic act_t smax(input act_t a, input act_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One pooled-row of horizontal maxima, written on even rows and read on odd rows.
module pool_line_buffer
   import cnn_pkg::*;
(
   input  logic                clock,
   input  logic                i_we,
   input  logic [LB_IDX_W-1:0] i_idx,
   input  act_t                i_wdata,
   output act_t                o_rdata
);

   act_t r_mem [LB_DEPTH];

   // Write port; contents need no reset since every entry is written before read.
   always_ff @(posedge clock) begin
      if (i_we) begin
         r_mem[i_idx] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool over a channel-major feature map.
module maxpool2x2_stream
   import cnn_pkg::*;
(
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done
);

   pool_state_t        r_state;
   pool_state_t        w_state_nxt;
   logic [COL_W-1:0]   r_col;
   logic [ROW_W-1:0]   r_row;
   logic [CH_W-1:0]    r_ch;
   logic               r_in_done;
   act_t               r_hold;
   logic               r_out_valid;
   logic               r_out_last;
   act_t               r_out_data;
   logic               r_busy;
   logic               r_done;

   logic               w_start_frame;
   logic               w_accept;
   logic               w_load;
   logic               w_out_xfer;
   logic               w_col_last;
   logic               w_row_last;
   logic               w_pix_last;
   logic               w_lb_we;
   logic [LB_IDX_W-1:0] w_lb_idx;
   act_t               w_lb_rdata;
   act_t               w_hmax;

   assign w_start_frame = start && (r_state != ST_RUN);
   assign w_out_xfer    = r_out_valid && out_ready;
   assign in_ready      = (r_state == ST_RUN) && !r_in_done && !(r_out_valid && !out_ready);
   assign w_accept      = in_valid && in_ready;
   assign w_col_last    = (r_col == COL_W'(IN_W - 1));
   assign w_row_last    = (r_row == ROW_W'(IN_H - 1));
   assign w_pix_last    = w_col_last && w_row_last && (r_ch == CH_W'(CHANNELS - 1));
   assign w_hmax        = smax(r_hold, in_data);
   assign w_lb_idx      = LB_IDX_W'(r_col >> 1);
   assign w_lb_we       = w_accept && r_col[0] && !r_row[0];
   assign w_load        = w_accept && r_col[0] && r_row[0];

   pool_line_buffer u_line_buf (
      .clock   (clock),
      .i_we    (w_lb_we),
      .i_idx   (w_lb_idx),
      .i_wdata (w_hmax),
      .o_rdata (w_lb_rdata)
   );

   // State register with registered status flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == ST_RUN);
         r_done  <= (w_state_nxt == ST_DONE);
      end
   end

   // Next-state logic: frame ends when the final result leaves downstream.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start) w_state_nxt = ST_RUN;
         ST_RUN:  if (w_out_xfer && r_out_last) w_state_nxt = ST_DONE;
         ST_DONE: if (start) w_state_nxt = ST_RUN;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Raster position counters, advanced only on accepted pixels.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_col     <= '0;
         r_row     <= '0;
         r_ch      <= '0;
         r_in_done <= 1'b0;
      end else if (w_start_frame) begin
         r_col     <= '0;
         r_row     <= '0;
         r_ch      <= '0;
         r_in_done <= 1'b0;
      end else if (w_accept) begin
         r_col <= w_col_last ? '0 : r_col + COL_W'(1);
         if (w_col_last) begin
            r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
            if (w_row_last) begin
               r_ch <= r_ch + CH_W'(1);
            end
         end
         if (w_pix_last) begin
            r_in_done <= 1'b1;
         end
      end
   end

   // Even-column pixel held for the horizontal compare.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_hold <= '0;
      end else if (w_accept && !r_col[0]) begin
         r_hold <= in_data;
      end
   end

   // Output register: a new load wins over a same-cycle downstream accept.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_data  <= smax(w_lb_rdata, w_hmax);
         r_out_last  <= w_pix_last;
      end else if (w_out_xfer) begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: doc/maxpool2x2_stream.md
Name: maxpool2x2_stream

Overview:
- Streaming 2x2/stride-2 signed max-pool stage directly upstream of the dense layer.
- Consumes conv-layer activations as a 20x20x16 feature map and emits the 10x10x16 = 1600 pooled 12-bit activations the dense layer flattens.
- Pixels arrive channel-major, rows top-to-bottom, columns left-to-right, over a valid/ready stream. Pooled results leave in the same order on a registered valid/ready stream.

Parameters:
- DATA_W, 12, signed activation width in and out.
- IN_W, 20, input map width; must be even.
- IN_H, 20, input map height; must be even.
- CHANNELS, 16, number of planes per frame.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin a frame; sampled only in IDLE or DONE.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept the pixel this cycle.
- in_data  in  DATA_W  signed input pixel.
- out_valid  out  1  pooled result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  signed pooled maximum.
- out_last  out  1  high with the 1600th (final) result of the frame.
- busy  out  1  high in RUN.
- done  out  1  high in DONE, held until the next start.

Behaviour:
- Interface: one clock `clock`; reset `reset_n` is asynchronous and active-low.
- Reset: state=IDLE; counters=0; out_valid=0, out_data=0, out_last=0, busy=0, done=0. The line buffer is not cleared, because every location is written before it is read.
- Reset asserted mid-frame aborts the frame immediately; no partial output is produced afterwards.
- FSM:
  - IDLE --start--> RUN: clears col/row/ch counters.
  - RUN --final output accepted downstream--> DONE.
  - DONE --start--> RUN.
  - start during RUN is ignored.
- in_ready is 0 outside RUN. In RUN, in_ready = !(out_valid && !out_ready), with one exception: after the frame's last pixel is accepted, in_ready=0.
- A pixel is accepted when in_valid && in_ready. Counters advance only on acceptance:
  - col wraps at IN_W-1 and increments row;
  - row wraps at IN_H-1 and increments ch;
  - ch reaching CHANNELS marks the frame complete.
- Per accepted pixel:
  - Even col: hold_reg <= in_data.
  - Odd col: hmax = signed max(hold_reg, in_data).
  - Even row, odd col: line_buf[col>>1] <= hmax.
  - Odd row, odd col: out_data <= signed max(line_buf[col>>1], hmax); out_valid <= 1 on the next edge. Latency is 1 cycle from acceptance to out_valid.
- Output register:
  - out_valid clears when out_ready && out_valid and no new result is loaded in the same cycle.
  - If a result is accepted downstream and a new one is loaded in the same cycle, out_valid stays 1 and out_data takes the new value.
- Results are never dropped or duplicated. Backpressure stalls input via in_ready.
- out_last = 1 with result index 1599 (ch=15, pooled row 9, pooled col 9), and only while that result is valid.
- Comparisons are full DATA_W signed, no saturation. Equal values return that value.
- Input stalls (in_valid=0) at any position, including between the even and odd pixel of a pair, preserve all state.

Decomposition:
- Shared package `cnn_pkg`:
  - DATA_W, IN_W, IN_H, CHANNELS;
  - POOL_OUT_COUNT = (IN_W/2)*(IN_H/2)*CHANNELS = 1600;
  - typedef act_t = signed [DATA_W-1:0];
  - a signed max function.
- Sub-module `pool_line_buffer`:
  - IN_W/2 x DATA_W register array;
  - one write port and one combinational read port, same index;
  - no reset.

Test Plan:
- Ramp: pixel value = (col + 20*row) mod 2048 for ch 0, all-ready stream. First output = 21 (pixels 0,1,20,21); out 10 (pooled row 1, col 0) = 61; exactly 100 outputs for ch 0.
- Signed: a window of {-5, -2048, -1, -300} -> -1. A window of {2047, -2048, 0, 0} -> 2047.
- Full frame with random data and a reference model: 1600 outputs matching the model; out_last only on #1600; then done=1, busy=0, in_ready=0.
- Backpressure: out_ready=0 for 7 cycles when out 3 is valid. out_valid and out_data hold; in_ready=0 once the next result is ready to load; resuming gives no loss or duplicate.
- Input bubbles: in_valid toggled randomly, including between pair halves; outputs are identical to the no-bubble run.
- Reset mid-frame after 300 inputs: out_valid=0, state IDLE, done=0 asynchronously. Then start plus a full frame gives the correct 1600 results.
